// File: rtl/tdm_demux4_if.sv
// Bus bundle between the serial link and the 4-channel TDM demultiplexer:
// the serial word stream in, the parallel frame and link status out.
interface tdm_demux4_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] In_Data;
  logic             In_Valid;
  logic             In_Sync;
  logic [WIDTH-1:0] Out_A;
  logic [WIDTH-1:0] Out_B;
  logic [WIDTH-1:0] Out_C;
  logic [WIDTH-1:0] Out_D;
  logic             Frame_Valid;
  logic             Sync_Err;
  logic             Locked;
  logic [1:0]       Slot;

  // Link side: drives the serial stream and observes the decoded frame.
  modport master (
    output In_Data, In_Valid, In_Sync,
    input  Out_A, Out_B, Out_C, Out_D, Frame_Valid, Sync_Err, Locked, Slot
  );

  // Demultiplexer side.
  modport slave (
    input  In_Data, In_Valid, In_Sync,
    output Out_A, Out_B, Out_C, Out_D, Frame_Valid, Sync_Err, Locked, Slot
  );
endinterface

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: tracks the slot of a sync-marked serial stream,
// assembles complete frames and presents them in parallel with a one-cycle strobe.
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input logic          Clock,
  input logic          Reset_n,
  tdm_demux4_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] h0_q, h0_d;
  logic [WIDTH-1:0] h1_q, h1_d;
  logic [WIDTH-1:0] h2_q, h2_d;
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic [WIDTH-1:0] out_c_q, out_c_d;
  logic [WIDTH-1:0] out_d_q, out_d_d;
  logic             frame_valid_q, frame_valid_d;
  logic             sync_err_q, sync_err_d;

  // Next-state, slot tracking, frame assembly and event pulses.
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    h0_d          = h0_q;
    h1_d          = h1_q;
    h2_d          = h2_q;
    out_a_d       = out_a_q;
    out_b_d       = out_b_q;
    out_c_d       = out_c_q;
    out_d_d       = out_d_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;

    if (bus.In_Valid) begin
      case (state_q)
        ST_HUNT: begin
          if (bus.In_Sync) begin
            h0_d    = bus.In_Data;
            slot_d  = 2'd1;
            state_d = ST_RUN;
          end else begin
            state_d = ST_HUNT;
          end
        end

        ST_RUN: begin
          if (bus.In_Sync && (slot_q != 2'd0)) begin
            // Early sync: restart the frame on this word, dropping the partial one.
            sync_err_d = 1'b1;
            h0_d       = bus.In_Data;
            slot_d     = 2'd1;
          end else if (!bus.In_Sync && (slot_q == 2'd0)) begin
            sync_err_d = 1'b1;
            slot_d     = 2'd0;
            state_d    = ST_HUNT;
          end else begin
            case (slot_q)
              2'd0: begin
                h0_d   = bus.In_Data;
                slot_d = 2'd1;
              end
              2'd1: begin
                h1_d   = bus.In_Data;
                slot_d = 2'd2;
              end
              2'd2: begin
                h2_d   = bus.In_Data;
                slot_d = 2'd3;
              end
              2'd3: begin
                out_a_d       = h0_q;
                out_b_d       = h1_q;
                out_c_d       = h2_q;
                out_d_d       = bus.In_Data;
                frame_valid_d = 1'b1;
                slot_d        = 2'd0;
              end
              default: begin
                slot_d  = 2'd0;
                state_d = ST_HUNT;
              end
            endcase
          end
        end

        default: begin
          slot_d  = 2'd0;
          state_d = ST_HUNT;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, hold and output registers; reset clears everything at once.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= ST_HUNT;
      slot_q        <= 2'd0;
      h0_q          <= {WIDTH{1'b0}};
      h1_q          <= {WIDTH{1'b0}};
      h2_q          <= {WIDTH{1'b0}};
      out_a_q       <= {WIDTH{1'b0}};
      out_b_q       <= {WIDTH{1'b0}};
      out_c_q       <= {WIDTH{1'b0}};
      out_d_q       <= {WIDTH{1'b0}};
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      h0_q          <= h0_d;
      h1_q          <= h1_d;
      h2_q          <= h2_d;
      out_a_q       <= out_a_d;
      out_b_q       <= out_b_d;
      out_c_q       <= out_c_d;
      out_d_q       <= out_d_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign bus.Out_A       = out_a_q;
  assign bus.Out_B       = out_b_q;
  assign bus.Out_C       = out_c_q;
  assign bus.Out_D       = out_d_q;
  assign bus.Frame_Valid = frame_valid_q;
  assign bus.Sync_Err    = sync_err_q;
  assign bus.Locked      = (state_q == ST_RUN);
  assign bus.Slot        = slot_q;

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer. It is the receive end of the 4:1 channel-selection path. A serial word stream carries four channels in fixed slot order, and a sync flag marks the channel-A word. The block tracks the slot, collects a full frame, and presents all four channels in parallel with a one-cycle frame strobe. It sits between the serial link and the ALU operand registers, and detects and recovers from loss of frame alignment.

## Interface
- WIDTH, 8, bits per channel word
- Clock  in  1  rising-edge system clock
- Reset_n  in  1  asynchronous, active-low reset
- In_Data  in  WIDTH  serial word for the current slot
- In_Valid  in  1  In_Data/In_Sync valid this cycle; word accepted on the rising edge
- In_Sync  in  1  marks the word as slot 0 (channel A); ignored when In_Valid=0
- Out_A  out  WIDTH  channel A (slot 0) of the last complete frame
- Out_B  out  WIDTH  channel B (slot 1) of the last complete frame
- Out_C  out  WIDTH  channel C (slot 2) of the last complete frame
- Out_D  out  WIDTH  channel D (slot 3) of the last complete frame
- Frame_Valid  out  1  one-cycle pulse: Out_A..Out_D just updated
- Sync_Err  out  1  one-cycle pulse: alignment violation detected
- Locked  out  1  high while in RUN state
- Slot  out  2  slot index expected for the next accepted word

## Operation
- Internal storage: hold registers H0..H2 (WIDTH each), 2-bit slot counter, state register.
- Two states: HUNT and RUN.
- Reset (Reset_n=0, asynchronous) forces:
  - state HUNT, Slot=0, Locked=0
  - H0..H2=0, Out_A..Out_D=0
  - Frame_Valid=0, Sync_Err=0
- Cycles with In_Valid=0 change nothing. Gaps of any length are legal mid-frame.
- HUNT, on each accepted word:
  - In_Sync=1: H0<=In_Data, Slot<=1, go to RUN, Locked<=1.
  - In_Sync=0: word discarded, no Sync_Err.
- RUN, on each accepted word, cases in priority order:
  - In_Sync=1 and Slot!=0 (early sync): Sync_Err pulse, partial frame discarded, H0<=In_Data, Slot<=1, stay in RUN.
  - In_Sync=0 and Slot=0 (missing sync): Sync_Err pulse, word discarded, go to HUNT, Locked<=0, Slot<=0.
  - Slot=1 or 2: H[Slot]<=In_Data, Slot<=Slot+1.
  - Slot=0 with In_Sync=1: H0<=In_Data, Slot<=1.
  - Slot=3 with In_Sync=0 (frame complete): Out_A<=H0, Out_B<=H1, Out_C<=H2, Out_D<=In_Data, Frame_Valid<=1, Slot wraps to 0.
- Out_A..Out_D hold their value until the next complete frame. Discarded partial frames never reach the outputs.
- Slot is the registered counter value. It wraps 3->0 only through frame completion.

## Timing
- Every output is registered. No combinational input-to-output path.
- Frame_Valid and the Out_A..Out_D update are visible in the cycle after the edge that accepts the slot-3 word.
  - Latency: 1 clock from the last word.
- Frame_Valid and Sync_Err each last exactly one cycle per event. Both are cleared on the next edge unless a new event occurs.
- Frame_Valid and Sync_Err are never high in the same cycle.
- Back-to-back frames at full rate (In_Valid held high) give one Frame_Valid every 4 cycles.
- Locked follows the state register: it rises the cycle after the first sync word is accepted, and falls the cycle after a missing-sync error.
- Reset asserted mid-frame clears all state and outputs immediately, without waiting for a clock edge. After release, the first sync word accepted is treated as a HUNT entry.

## Test plan
- Reset, then four valid words 0x11(sync), 0x22, 0x33, 0x44 on consecutive cycles -> Out_A..D = 0x11/0x22/0x33/0x44, Frame_Valid high for exactly 1 cycle, Locked=1, Slot=0.
- Words 0x55, 0x66 (no sync) after reset -> discarded; Locked=0, no Sync_Err, outputs stay 0. Then 0xA0(sync), 0xA1, 0xA2, 0xA3 -> outputs A0/A1/A2/A3.
- Locked; words 0x01(sync), 0x02, then 0x10(sync), 0x20, 0x30, 0x40 -> Sync_Err pulse on the second sync; the next frame output is 10/20/30/40; 0x01/0x02 never appear on the outputs.
- Locked with Slot=0; word 0x99 with In_Sync=0 -> Sync_Err pulse, Locked=0, Out_* unchanged from the previous frame.
- Frame 0xC1..0xC4 with In_Valid deasserted for 3 cycles between each pair of words -> identical result to the gap-free case; Frame_Valid fires once, 1 cycle after 0xC4.
- Reset_n pulsed low between clock edges after two words of a frame -> outputs and Slot go to 0 immediately and Locked=0; a following full frame 0xE1..0xE4 decodes correctly.
